// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: elastic pipeline register built from DEPTH
// cascaded skid-buffered stages with stall, flush and bubble fill.
module pipe_skid_stage #(
    parameter int unsigned      WIDTH  = 32,
    parameter int unsigned      DEPTH  = 1,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(2*DEPTH+1)-1:0] occupancy
);

    localparam int unsigned OCC_W = $clog2(2*DEPTH+1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           st_q   [DEPTH];
    state_t           st_d   [DEPTH];
    logic [WIDTH-1:0] main_q [DEPTH];
    logic [WIDTH-1:0] main_d [DEPTH];
    logic [WIDTH-1:0] skid_q [DEPTH];
    logic [WIDTH-1:0] skid_d [DEPTH];
    logic [DEPTH-1:0] rdy_q;
    logic [DEPTH-1:0] rdy_d;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // Handshake chain: index k is the link entering stage k,
    // index DEPTH is the link leaving the last stage.
    logic [DEPTH:0]   v_chain;
    logic [DEPTH:0]   r_chain;
    logic [WIDTH-1:0] d_chain [DEPTH];
    logic [DEPTH-1:0] acc;
    logic [DEPTH-1:0] dep;

    // Stitch stages together and derive per-stage transfers.
    always_comb begin
        v_chain[0]     = in_valid & ~flush;
        d_chain[0]     = in_data;
        r_chain[DEPTH] = out_ready;
        for (int k = 0; k < DEPTH; k++) begin
            v_chain[k+1] = (st_q[k] != ST_EMPTY);
            r_chain[k]   = rdy_q[k];
        end
        for (int k = 1; k < DEPTH; k++) begin
            d_chain[k] = main_q[k-1];
        end
        for (int k = 0; k < DEPTH; k++) begin
            acc[k] = v_chain[k] & r_chain[k];
            dep[k] = v_chain[k+1] & r_chain[k+1];
        end
    end

    // Per-stage skid state machine; flush overrides everything.
    always_comb begin
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            st_d[k]   = st_q[k];
            main_d[k] = main_q[k];
            skid_d[k] = skid_q[k];
            case (st_q[k])
                ST_EMPTY: begin
                    if (acc[k]) begin
                        st_d[k]   = ST_BUSY;
                        main_d[k] = d_chain[k];
                    end
                end
                ST_BUSY: begin
                    if (acc[k] && dep[k]) begin
                        main_d[k] = d_chain[k];
                    end else if (acc[k]) begin
                        st_d[k]   = ST_FULL;
                        skid_d[k] = d_chain[k];
                    end else if (dep[k]) begin
                        st_d[k]   = ST_EMPTY;
                        main_d[k] = BUBBLE;
                    end
                end
                ST_FULL: begin
                    if (dep[k]) begin
                        st_d[k]   = ST_BUSY;
                        main_d[k] = skid_q[k];
                        skid_d[k] = BUBBLE;
                    end
                end
                default: begin
                    st_d[k]   = ST_EMPTY;
                    main_d[k] = BUBBLE;
                    skid_d[k] = BUBBLE;
                end
            endcase
            if (flush) begin
                st_d[k]   = ST_EMPTY;
                main_d[k] = BUBBLE;
                skid_d[k] = BUBBLE;
            end
            rdy_d[k] = (st_d[k] != ST_FULL);
            case (st_d[k])
                ST_BUSY: occ_d = occ_d + OCC_W'(1);
                ST_FULL: occ_d = occ_d + OCC_W'(2);
                default: occ_d = occ_d;
            endcase
        end
    end

    // State, data, ready flags and occupancy registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++) begin
                st_q[k]   <= ST_EMPTY;
                main_q[k] <= BUBBLE;
                skid_q[k] <= BUBBLE;
            end
            rdy_q <= '0;
            occ_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                st_q[k]   <= st_d[k];
                main_q[k] <= main_d[k];
                skid_q[k] <= skid_d[k];
            end
            rdy_q <= rdy_d;
            occ_q <= occ_d;
        end
    end

    assign in_ready  = rdy_q[0] & ~flush;
    assign out_valid = v_chain[DEPTH];
    assign out_data  = main_q[DEPTH-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed table, hand sequences and a
// random scoreboard run over several chain depths.
module tb_pipe_skid_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // a: DEPTH=3
    logic a_rst, a_fl, a_iv, a_ir, a_ov, a_or;
    logic [31:0] a_id, a_od;
    logic [2:0] a_occ;
    // b: DEPTH=2
    logic b_rst, b_fl, b_iv, b_ir, b_ov, b_or;
    logic [31:0] b_id, b_od;
    logic [2:0] b_occ;
    // c: DEPTH=4
    logic c_rst, c_fl, c_iv, c_ir, c_ov, c_or;
    logic [31:0] c_id, c_od;
    logic [3:0] c_occ;
    // e: DEPTH=1, WIDTH=1
    logic e_rst, e_fl, e_iv, e_ir, e_ov, e_or;
    logic e_id, e_od;
    logic [1:0] e_occ;

    pipe_skid_stage #(.WIDTH(32), .DEPTH(3), .BUBBLE(NOP)) u_a (
        .clk(clk), .resetn(a_rst), .flush(a_fl),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .occupancy(a_occ));

    pipe_skid_stage #(.WIDTH(32), .DEPTH(2), .BUBBLE(NOP)) u_b (
        .clk(clk), .resetn(b_rst), .flush(b_fl),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .occupancy(b_occ));

    pipe_skid_stage #(.WIDTH(32), .DEPTH(4), .BUBBLE(NOP)) u_c (
        .clk(clk), .resetn(c_rst), .flush(c_fl),
        .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
        .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
        .occupancy(c_occ));

    pipe_skid_stage #(.WIDTH(1), .DEPTH(1), .BUBBLE(1'b0)) u_e (
        .clk(clk), .resetn(e_rst), .flush(e_fl),
        .in_valid(e_iv), .in_ready(e_ir), .in_data(e_id),
        .out_valid(e_ov), .out_ready(e_or), .out_data(e_od),
        .occupancy(e_occ));

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        ir;
        logic        ov;
        logic [31:0] od;
        logic [2:0]  occ;
    } vec_t;

    vec_t tbl [10];

    logic [31:0] cq [$];
    logic        eq [$];
    logic [31:0] exp32;
    logic        exp1;

    initial begin
        int n;
        int pushed;
        int popped;
        int over;
        int seen;

        tbl[0] = '{1'b1, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0, NOP, 3'd0};
        tbl[1] = '{1'b1, 32'h2, 1'b1, 1'b0, 1'b1, 1'b0, NOP, 3'd1};
        tbl[2] = '{1'b1, 32'h3, 1'b1, 1'b0, 1'b1, 1'b0, NOP, 3'd2};
        tbl[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1, 3'd3};
        tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2, 3'd2};
        tbl[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3, 3'd1};
        tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, NOP, 3'd0};
        tbl[7] = '{1'b1, 32'h4, 1'b1, 1'b0, 1'b1, 1'b0, NOP, 3'd0};
        tbl[8] = '{1'b1, 32'h5, 1'b1, 1'b1, 1'b0, 1'b0, NOP, 3'd1};
        tbl[9] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, NOP, 3'd0};

        {a_rst, a_fl, a_iv, a_or, a_id} = '0;
        {b_rst, b_fl, b_iv, b_or, b_id} = '0;
        {c_rst, c_fl, c_iv, c_or, c_id} = '0;
        {e_rst, e_fl, e_iv, e_or, e_id} = '0;

        // reset values
        @(negedge clk); #1;
        chk("rst.a_out_valid", 64'(a_ov), 64'(0));
        chk("rst.a_occ", 64'(a_occ), 64'(0));
        chk("rst.a_out_data", 64'(a_od), 64'(NOP));
        chk("rst.e_out_data", 64'(e_od), 64'(0));
        @(negedge clk);
        {a_rst, b_rst, c_rst, e_rst} = 4'hF;
        @(negedge clk); #1;
        chk("rst.a_in_ready", 64'(a_ir), 64'(1));

        // DEPTH=3 latency, order and flush table
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_iv = tbl[i].iv;
            a_id = tbl[i].d;
            a_or = tbl[i].ordy;
            a_fl = tbl[i].fl;
            #1;
            chk($sformatf("tbl%0d.in_ready", i), 64'(a_ir), 64'(tbl[i].ir));
            chk($sformatf("tbl%0d.out_valid", i), 64'(a_ov), 64'(tbl[i].ov));
            chk($sformatf("tbl%0d.out_data", i), 64'(a_od), 64'(tbl[i].od));
            chk($sformatf("tbl%0d.occ", i), 64'(a_occ), 64'(tbl[i].occ));
        end

        // DEPTH=3 reset mid-stream with 5 held entries
        n = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a_fl = 1'b0;
            a_or = 1'b0;
            a_iv = (n < 5);
            a_id = 32'(32'h50 + n);
            #1;
            if (a_iv && a_ir) n++;
        end
        @(negedge clk);
        a_iv = 1'b0;
        #1;
        chk("mid.pushes", 64'(n), 64'(5));
        chk("mid.occ", 64'(a_occ), 64'(5));
        a_rst = 1'b0;
        #1;
        chk("mid.rst_out_valid", 64'(a_ov), 64'(0));
        chk("mid.rst_occ", 64'(a_occ), 64'(0));
        chk("mid.rst_out_data", 64'(a_od), 64'(NOP));
        @(negedge clk);
        a_rst = 1'b1;
        @(negedge clk);
        a_iv = 1'b1;
        a_id = 32'h77;
        a_or = 1'b1;
        #1;
        chk("mid.rel_in_ready", 64'(a_ir), 64'(1));
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            a_iv = 1'b0;
            #1;
            chk($sformatf("mid.lat%0d_valid", c), 64'(a_ov), 64'(c == 3));
        end
        chk("mid.lat_data", 64'(a_od), 64'(32'h77));

        // DEPTH=2 backpressure absorbs exactly 4
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b_iv = 1'b1;
            b_id = 32'(32'hA0 + n);
            #1;
            if (b_ir) n++;
        end
        @(negedge clk);
        b_iv = 1'b0;
        #1;
        chk("bp.accepts", 64'(n), 64'(4));
        chk("bp.in_ready", 64'(b_ir), 64'(0));
        chk("bp.occ", 64'(b_occ), 64'(4));
        b_or = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                @(negedge clk); #1;
            end
            if (c < 4) begin
                chk($sformatf("bp.drain%0d_valid", c), 64'(b_ov), 64'(1));
                chk($sformatf("bp.drain%0d_data", c), 64'(b_od),
                    64'(32'hA0 + c));
            end else begin
                chk("bp.drain_end", 64'(b_ov), 64'(0));
            end
            if (c == 2) chk("bp.ready_back", 64'(b_ir), 64'(1));
        end

        // DEPTH=2 flush with 3 held and a same-cycle input
        b_or = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b_iv = (n < 3);
            b_id = 32'(32'h10 + n);
            #1;
            if (b_iv && b_ir) n++;
        end
        @(negedge clk);
        b_iv = 1'b1;
        b_id = 32'hBEEF;
        b_fl = 1'b1;
        #1;
        chk("fl.occ_before", 64'(b_occ), 64'(3));
        chk("fl.in_ready", 64'(b_ir), 64'(0));
        @(negedge clk);
        b_fl = 1'b0;
        b_iv = 1'b0;
        b_or = 1'b1;
        #1;
        chk("fl.occ", 64'(b_occ), 64'(0));
        chk("fl.out_valid", 64'(b_ov), 64'(0));
        chk("fl.out_data", 64'(b_od), 64'(NOP));
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (b_ov) seen++;
        end
        chk("fl.no_emit", 64'(seen), 64'(0));

        // DEPTH=1 WIDTH=1 alternating out_ready
        popped = 0;
        over = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            e_iv = 1'b1;
            e_id = 1'($urandom_range(0, 1));
            e_or = 1'(i % 2);
            #1;
            if (e_occ > 2'd2) over++;
            if (e_ov && e_or) begin
                popped++;
                if (eq.size() == 0) begin
                    chk("w1.pop_empty", 64'(1), 64'(0));
                end else begin
                    exp1 = eq.pop_front();
                    chk("w1.data", 64'(e_od), 64'(exp1));
                end
            end
            if (e_iv && e_ir) eq.push_back(e_id);
        end
        chk("w1.pops", 64'(popped), 64'(20));
        chk("w1.over2", 64'(over), 64'(0));
        e_iv = 1'b0;

        // DEPTH=4 random traffic against a FIFO scoreboard
        pushed = 0;
        popped = 0;
        for (int i = 0; i < 60000 && pushed < 10000; i++) begin
            @(negedge clk);
            c_iv = 1'($urandom_range(0, 1));
            c_id = $urandom;
            c_or = 1'($urandom_range(0, 1));
            #1;
            chk("rnd.occ", 64'(c_occ), 64'(pushed - popped));
            if (!c_ov) chk("rnd.bubble", 64'(c_od), 64'(NOP));
            if (c_ov && c_or) begin
                popped++;
                if (cq.size() == 0) begin
                    chk("rnd.pop_empty", 64'(1), 64'(0));
                end else begin
                    exp32 = cq.pop_front();
                    chk("rnd.data", 64'(c_od), 64'(exp32));
                end
            end
            if (c_iv && c_ir) begin
                cq.push_back(c_id);
                pushed++;
            end
        end
        chk("rnd.pushed", 64'(pushed), 64'(10000));
        for (int i = 0; i < 64 && cq.size() > 0; i++) begin
            @(negedge clk);
            c_iv = 1'b0;
            c_or = 1'b1;
            #1;
            if (c_ov) begin
                popped++;
                exp32 = cq.pop_front();
                chk("rnd.drain", 64'(c_od), 64'(exp32));
            end
        end
        chk("rnd.left", 64'(cq.size()), 64'(0));
        chk("rnd.popped", 64'(popped), 64'(pushed));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
